// File: rtl/ascon_io_pkg.sv
// Shared state encoding and constant helpers for the Ascon serial front-end.
package ascon_io_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ARMED  = 3'd2,
    RUN    = 3'd3,
    UNLOAD = 3'd4
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ascon_serial_shift.sv
// Single-operand MSB-first deserialiser: load index i lands in bit W-1-i,
// indices at or beyond W are dropped.
module ascon_serial_shift
  import ascon_io_pkg::*;
#(
  parameter int W    = 128,
  parameter int LMAX = 128,
  localparam int SW  = clog2(LMAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [SW-1:0] idx_i,
  input  logic          bit_i,
  output logic [W-1:0]  data_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
    end else if (wr_en_i) begin
      for (int i = 0; i < W; i++) begin
        if (idx_i == SW'(W - 1 - i)) data_q[i] <= bit_i;
      end
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/ascon_serial_io.sv
// Serial loader/unloader around the Ascon core: MSB-first load of four operands,
// one-cycle core start, LSB-first unload of text and tag under ready/valid.
module ascon_serial_io
  import ascon_io_pkg::*;
#(
  parameter int K = 128,
  parameter int L = 40,
  parameter int Y = 40,
  parameter int T = 128,
  parameter int N = 128,
  localparam int LMAX = max2(max2(K, N), max2(L, Y)),
  localparam int UMAX = max2(Y, T)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  input  logic         key_bit,
  input  logic         nonce_bit,
  input  logic         ad_bit,
  input  logic         text_bit,
  input  logic         start,
  output logic [K-1:0] key,
  output logic [N-1:0] nonce,
  output logic [L-1:0] associated_data,
  output logic [Y-1:0] text_in,
  output logic         core_start,
  input  logic         core_ready,
  input  logic [Y-1:0] core_text,
  input  logic [T-1:0] core_tag,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         text_bit_out,
  output logic         tag_bit_out,
  output logic         load_done,
  output logic         busy
);

  localparam int CW = clog2(max2(LMAX, UMAX) + 1);
  localparam int SW = clog2(LMAX + 1);
  localparam logic [CW-1:0] LOAD_LAST   = CW'(LMAX - 1);
  localparam logic [CW-1:0] UNLOAD_LAST = CW'(UMAX - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          core_start_q, out_valid_q, load_done_q, busy_q;
  logic [Y-1:0]  res_text_q;
  logic [T-1:0]  res_tag_q;

  logic          load_en;
  logic [SW-1:0] load_idx;
  logic [Y-1:0]  text_sel;
  logic [T-1:0]  tag_sel;

  // A valid bit in IDLE or ARMED always (re)starts the load at index 0.
  assign load_en  = load_valid && (state_q == IDLE || state_q == LOAD || state_q == ARMED);
  assign load_idx = (state_q == LOAD) ? cnt_q[SW-1:0] : '0;

  ascon_serial_shift #(.W(K), .LMAX(LMAX)) u_key (
    .clk(clk), .rst(rst), .wr_en_i(load_en), .idx_i(load_idx), .bit_i(key_bit), .data_o(key));
  ascon_serial_shift #(.W(N), .LMAX(LMAX)) u_nonce (
    .clk(clk), .rst(rst), .wr_en_i(load_en), .idx_i(load_idx), .bit_i(nonce_bit), .data_o(nonce));
  ascon_serial_shift #(.W(L), .LMAX(LMAX)) u_ad (
    .clk(clk), .rst(rst), .wr_en_i(load_en), .idx_i(load_idx), .bit_i(ad_bit),
    .data_o(associated_data));
  ascon_serial_shift #(.W(Y), .LMAX(LMAX)) u_text (
    .clk(clk), .rst(rst), .wr_en_i(load_en), .idx_i(load_idx), .bit_i(text_bit), .data_o(text_in));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      core_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      load_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      res_text_q   <= '0;
      res_tag_q    <= '0;
    end else begin
      core_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            state_q <= LOAD;
            cnt_q   <= CW'(1);
          end
        end
        LOAD: begin
          if (load_valid) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LOAD_LAST) begin
              state_q     <= ARMED;
              load_done_q <= 1'b1;
            end
          end
        end
        ARMED: begin
          if (load_valid) begin
            state_q     <= LOAD;
            cnt_q       <= CW'(1);
            load_done_q <= 1'b0;
          end else if (start) begin
            state_q      <= RUN;
            core_start_q <= 1'b1;
            load_done_q  <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        RUN: begin
          if (core_ready) begin
            state_q     <= UNLOAD;
            res_text_q  <= core_text;
            res_tag_q   <= core_tag;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
          end
        end
        UNLOAD: begin
          if (out_ready) begin
            if (cnt_q == UNLOAD_LAST) begin
              state_q     <= IDLE;
              cnt_q       <= '0;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Shifting past the operand width yields zero for the padding positions.
  assign text_sel     = res_text_q >> cnt_q;
  assign tag_sel      = res_tag_q >> cnt_q;
  assign text_bit_out = (state_q == UNLOAD) && text_sel[0];
  assign tag_bit_out  = (state_q == UNLOAD) && tag_sel[0];

  assign core_start = core_start_q;
  assign out_valid  = out_valid_q;
  assign load_done  = load_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ascon_serial_io.sv
// Directed bench for ascon_serial_io with K=N=T=128, L=Y=40.
module tb_ascon_serial_io;

  localparam logic [127:0] KEY1 = 128'h3ffa75efbd1705fa8f9ced62e5bb0be3;
  localparam logic [127:0] NON1 = 128'h9691163337dd55217ea2a6b21eaa19b2;
  localparam logic [39:0]  AD1  = 40'h4153434f4e;
  localparam logic [39:0]  TXT1 = 40'hc21061905f;
  localparam logic [127:0] TAG1 = 128'h0123456789abcdef0011223344556677;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load_valid = 1'b0;
  logic         key_bit = 1'b0, nonce_bit = 1'b0, ad_bit = 1'b0, text_bit = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key;
  logic [127:0] nonce;
  logic [39:0]  associated_data;
  logic [39:0]  text_in;
  logic         core_start;
  logic         core_ready = 1'b0;
  logic [39:0]  core_text = '0;
  logic [127:0] core_tag = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         text_bit_out, tag_bit_out;
  logic         load_done, busy;

  int n_checks = 0;
  int n_fails  = 0;
  int cs_cnt   = 0;

  ascon_serial_io #(.K(128), .L(40), .Y(40), .T(128), .N(128)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid),
    .key_bit(key_bit), .nonce_bit(nonce_bit), .ad_bit(ad_bit), .text_bit(text_bit),
    .start(start), .key(key), .nonce(nonce), .associated_data(associated_data),
    .text_in(text_in), .core_start(core_start), .core_ready(core_ready),
    .core_text(core_text), .core_tag(core_tag), .out_valid(out_valid),
    .out_ready(out_ready), .text_bit_out(text_bit_out), .tag_bit_out(tag_bit_out),
    .load_done(load_done), .busy(busy));

  always #5 clk = ~clk;

  always @(negedge clk) if (core_start === 1'b1) cs_cnt++;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start_mode: 0 never, 1 on odd bits (LOAD), 2 together with bit 0 only
  task automatic load_vec(input logic [127:0] k, input logic [127:0] n, input logic [39:0] a,
                          input logic [39:0] t, input bit gaps, input int start_mode);
    for (int i = 0; i < 128; i++) begin
      if (gaps && (i % 3 == 2)) begin
        load_valid = 1'b0;
        start      = 1'b0;
        tick();
      end
      if (i == 127) check_eq("load_done_before_last", {159'd0, load_done}, 160'd0);
      load_valid = 1'b1;
      key_bit    = k[127-i];
      nonce_bit  = n[127-i];
      ad_bit     = (i < 40) ? a[39-i] : 1'b0;
      text_bit   = (i < 40) ? t[39-i] : 1'b0;
      start      = (start_mode == 1 && (i % 2 == 1)) || (start_mode == 2 && i == 0);
      tick();
    end
    load_valid = 1'b0;
    start      = 1'b0;
    check_eq("key", {32'd0, key}, {32'd0, k});
    check_eq("nonce", {32'd0, nonce}, {32'd0, n});
    check_eq("ad", {120'd0, associated_data}, {120'd0, a});
    check_eq("text_in", {120'd0, text_in}, {120'd0, t});
    check_eq("load_done", {159'd0, load_done}, 160'd1);
  endtask

  task automatic run_core(input logic [39:0] ctext, input logic [127:0] ctag,
                          input logic [127:0] exp_key);
    int cs0;
    cs0   = cs_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("core_start_pulse", {159'd0, core_start}, 160'd1);
    check_eq("busy_run", {159'd0, busy}, 160'd1);
    check_eq("load_done_run", {159'd0, load_done}, 160'd0);
    load_valid = 1'b1;
    key_bit    = ~exp_key[127];
    start      = 1'b1;
    repeat (4) tick();
    load_valid = 1'b0;
    start      = 1'b0;
    check_eq("core_start_count", 160'(cs_cnt - cs0), 160'd1);
    check_eq("key_held_in_run", {32'd0, key}, {32'd0, exp_key});
    core_text  = ctext;
    core_tag   = ctag;
    core_ready = 1'b1;
    tick();
    core_ready = 1'b0;
    core_text  = '0;
    core_tag   = '0;
    check_eq("out_valid_first", {159'd0, out_valid}, 160'd1);
  endtask

  task automatic unload(input logic [39:0] etext, input logic [127:0] etag,
                        input int pause_at, input int abort_at);
    logic [127:0] got_text, got_tag;
    int invalid;
    got_text = '0;
    got_tag  = '0;
    invalid  = 0;
    for (int i = 0; i < 128; i++) begin
      if (i == abort_at) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_eq("abort_out_valid", {159'd0, out_valid}, 160'd0);
        check_eq("abort_busy", {159'd0, busy}, 160'd0);
        check_eq("abort_bits", {158'd0, text_bit_out, tag_bit_out}, 160'd0);
        check_eq("abort_key", {32'd0, key}, 160'd0);
        check_eq("abort_load_done", {159'd0, load_done}, 160'd0);
        return;
      end
      if (i == pause_at) begin
        out_ready = 1'b0;
        repeat (5) begin
          tick();
          check_eq("pause_tag_bit", {159'd0, tag_bit_out}, {159'd0, etag[i]});
          check_eq("pause_valid", {159'd0, out_valid}, 160'd1);
        end
      end
      if (out_valid !== 1'b1) invalid++;
      got_text[i] = text_bit_out;
      got_tag[i]  = tag_bit_out;
      out_ready   = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    check_eq("unload_valid_all", 160'(invalid), 160'd0);
    check_eq("unload_text", {120'd0, got_text[39:0]}, {120'd0, etext});
    check_eq("unload_text_pad", {72'd0, got_text[127:40]}, 160'd0);
    check_eq("unload_tag", {32'd0, got_tag}, {32'd0, etag});
    check_eq("out_valid_end", {159'd0, out_valid}, 160'd0);
    check_eq("busy_end", {159'd0, busy}, 160'd0);
  endtask

  initial begin
    int cs0;
    repeat (2) tick();
    check_eq("rst_key", {32'd0, key}, 160'd0);
    check_eq("rst_text_in", {120'd0, text_in}, 160'd0);
    check_eq("rst_flags", {155'd0, core_start, out_valid, load_done, busy, text_bit_out}, 160'd0);
    rst = 1'b1;
    tick();

    // Contiguous load with start toggling in LOAD, then full run with a stall at bit 17.
    cs0 = cs_cnt;
    load_vec(KEY1, NON1, AD1, TXT1, 1'b0, 1);
    check_eq("no_start_in_load", 160'(cs_cnt - cs0), 160'd0);
    run_core(40'h0, TAG1, KEY1);
    unload(40'h0, TAG1, 17, -1);

    // Registers cleared by reset, then gapped load restores the same values.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_eq("rst2_key", {32'd0, key}, 160'd0);
    load_vec(KEY1, NON1, AD1, TXT1, 1'b1, 0);

    // From ARMED: load_valid together with start reloads from bit 0, no core_start.
    cs0 = cs_cnt;
    load_vec(NON1, KEY1, TXT1, AD1, 1'b0, 2);
    check_eq("no_start_on_reload", 160'(cs_cnt - cs0), 160'd0);

    // Abort mid-unload with reset, then a fresh full cycle.
    run_core(TXT1, KEY1, NON1);
    unload(TXT1, KEY1, -1, 60);
    load_vec(KEY1, NON1, AD1, TXT1, 1'b0, 0);
    run_core(TXT1, TAG1, KEY1);
    unload(TXT1, TAG1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
